// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle controller and the shared datapath/memory.
// The master side is the controller; the slave side is the datapath that feeds
// it the instruction fields, ALU flag and memory handshake.
interface multicycle_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [5:0]       instr_op_i;
    logic [5:0]       funct_i;
    logic             zero_i;
    logic             mem_ready_i;
    logic             mem_req_o;
    logic             iord_o;
    logic             mem_we_o;
    logic             ir_write_o;
    logic             pc_write_o;
    logic [1:0]       pc_src_o;
    logic             reg_write_o;
    logic [1:0]       reg_dst_o;
    logic [1:0]       mem_to_reg_o;
    logic             alu_src_a_o;
    logic [1:0]       alu_src_b_o;
    logic [2:0]       alu_op_o;
    logic             trap_o;
    logic [CNT_W-1:0] instr_cnt_o;

    modport master (
        input  instr_op_i, funct_i, zero_i, mem_ready_i,
        output mem_req_o, iord_o, mem_we_o, ir_write_o, pc_write_o, pc_src_o,
               reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
               alu_op_o, trap_o, instr_cnt_o
    );

    modport slave (
        output instr_op_i, funct_i, zero_i, mem_ready_i,
        input  mem_req_o, iord_o, mem_we_o, ir_write_o, pc_write_o, pc_src_o,
               reg_write_o, reg_dst_o, mem_to_reg_o, alu_src_a_o, alu_src_b_o,
               alu_op_o, trap_o, instr_cnt_o
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences fetch/decode/execute/memory/writeback over
// the shared datapath, waits on a variable-latency memory handshake, and traps
// on an illegal opcode or when a memory access exceeds its wait budget.
// All controls are decoded from the registered state, so forcing the state to
// IDLE with the asynchronous reset drops every request and write enable at once.
module multicycle_ctrl #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    multicycle_ctrl_if.master bus
);
    localparam int WAIT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_TRAP   = 3'd6;

    localparam logic [3:0] C_R    = 4'd0;
    localparam logic [3:0] C_JR   = 4'd1;
    localparam logic [3:0] C_BEQ  = 4'd2;
    localparam logic [3:0] C_BNE  = 4'd3;
    localparam logic [3:0] C_J    = 4'd4;
    localparam logic [3:0] C_JAL  = 4'd5;
    localparam logic [3:0] C_LW   = 4'd6;
    localparam logic [3:0] C_SW   = 4'd7;
    localparam logic [3:0] C_ADDI = 4'd8;
    localparam logic [3:0] C_SLTI = 4'd9;
    localparam logic [3:0] C_ORI  = 4'd10;
    localparam logic [3:0] C_LUI  = 4'd11;
    localparam logic [3:0] C_ILL  = 4'd15;

    logic [2:0]        r_state;
    logic [3:0]        r_class;
    logic [WAIT_W-1:0] r_wait;
    logic [CNT_W-1:0]  r_cnt;

    logic [2:0] w_next;
    logic [3:0] w_class;
    logic       w_timeout;
    logic       w_retire;
    logic       w_mem_req, w_iord, w_mem_we, w_ir_write, w_pc_write, w_reg_write;
    logic       w_alu_src_a, w_trap;
    logic [1:0] w_pc_src, w_reg_dst, w_mem_to_reg, w_alu_src_b;
    logic [2:0] w_alu_op;

    assign w_timeout = (r_wait == WAIT_LAST) && !bus.mem_ready_i;
    assign w_retire  = (w_next == S_FETCH) &&
                       (r_state == S_DECODE || r_state == S_EXEC ||
                        r_state == S_MEM    || r_state == S_WB);

    // Classify the instruction currently held in IR; anything unlisted is illegal.
    always_comb begin
        w_class = C_ILL;
        case (bus.instr_op_i)
            6'd0:  w_class = (bus.funct_i == 6'd8) ? C_JR : C_R;
            6'd2:  w_class = C_J;
            6'd3:  w_class = C_JAL;
            6'd4:  w_class = C_BEQ;
            6'd5:  w_class = C_BNE;
            6'd8:  w_class = C_ADDI;
            6'd10: w_class = C_SLTI;
            6'd13: w_class = C_ORI;
            6'd15: w_class = C_LUI;
            6'd35: w_class = C_LW;
            6'd43: w_class = C_SW;
            default: w_class = C_ILL;
        endcase
    end

    // Next-state and per-cycle datapath controls, all zero unless the state asks.
    always_comb begin
        w_next       = r_state;
        w_mem_req    = 1'b0;
        w_iord       = 1'b0;
        w_mem_we     = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_pc_src     = 2'd0;
        w_reg_write  = 1'b0;
        w_reg_dst    = 2'd0;
        w_mem_to_reg = 2'd0;
        w_alu_src_a  = 1'b0;
        w_alu_src_b  = 2'd0;
        w_alu_op     = 3'd0;
        w_trap       = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                w_mem_req   = 1'b1;
                w_alu_src_b = 2'd1;
                if (bus.mem_ready_i) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_TRAP;
                end
            end
            S_DECODE: begin
                w_alu_src_b = 2'd3;
                w_next      = S_EXEC;
                case (w_class)
                    C_J: begin
                        w_pc_write = 1'b1;
                        w_pc_src   = 2'd2;
                        w_next     = S_FETCH;
                    end
                    C_JAL: begin
                        w_pc_write   = 1'b1;
                        w_pc_src     = 2'd2;
                        w_reg_write  = 1'b1;
                        w_reg_dst    = 2'd2;
                        w_mem_to_reg = 2'd3;
                        w_next       = S_FETCH;
                    end
                    C_JR: begin
                        w_pc_write = 1'b1;
                        w_pc_src   = 2'd3;
                        w_next     = S_FETCH;
                    end
                    C_ILL: w_next = S_TRAP;
                    default: w_next = S_EXEC;
                endcase
            end
            S_EXEC: begin
                w_alu_src_a = 1'b1;
                w_alu_src_b = 2'd2;
                w_next      = S_WB;
                case (r_class)
                    C_R: begin
                        w_alu_src_b = 2'd0;
                        w_alu_op    = 3'd2;
                    end
                    C_SLTI: w_alu_op = 3'd3;
                    C_ORI:  w_alu_op = 3'd4;
                    C_LUI:  w_alu_op = 3'd5;
                    C_LW, C_SW: w_next = S_MEM;
                    C_BEQ, C_BNE: begin
                        w_alu_src_b = 2'd0;
                        w_alu_op    = 3'd1;
                        w_pc_src    = 2'd1;
                        w_pc_write  = (r_class == C_BEQ) ? bus.zero_i : !bus.zero_i;
                        w_next      = S_FETCH;
                    end
                    default: w_alu_op = 3'd0;
                endcase
            end
            S_MEM: begin
                w_mem_req = 1'b1;
                w_iord    = 1'b1;
                w_mem_we  = (r_class == C_SW);
                if (bus.mem_ready_i) begin
                    w_next = (r_class == C_SW) ? S_FETCH : S_WB;
                end else if (w_timeout) begin
                    w_next = S_TRAP;
                end
            end
            S_WB: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = (r_class == C_R)  ? 2'd1 : 2'd0;
                w_mem_to_reg = (r_class == C_LW) ? 2'd1 : 2'd0;
                w_next       = S_FETCH;
            end
            S_TRAP: w_trap = 1'b1;
            default: w_next = S_IDLE;
        endcase
    end

    // State, latched class, memory wait counter and retired-instruction counter.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_class <= 4'd0;
            r_wait  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_class <= w_class;
            end
            if ((r_state == S_FETCH || r_state == S_MEM) && !bus.mem_ready_i) begin
                r_wait <= r_wait + WAIT_W'(1);
            end else begin
                r_wait <= '0;
            end
            if (w_retire) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.mem_req_o    = w_mem_req;
    assign bus.iord_o       = w_iord;
    assign bus.mem_we_o     = w_mem_we;
    assign bus.ir_write_o   = w_ir_write;
    assign bus.pc_write_o   = w_pc_write;
    assign bus.pc_src_o     = w_pc_src;
    assign bus.reg_write_o  = w_reg_write;
    assign bus.reg_dst_o    = w_reg_dst;
    assign bus.mem_to_reg_o = w_mem_to_reg;
    assign bus.alu_src_a_o  = w_alu_src_a;
    assign bus.alu_src_b_o  = w_alu_src_b;
    assign bus.alu_op_o     = w_alu_op;
    assign bus.trap_o       = w_trap;
    assign bus.instr_cnt_o  = r_cnt;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl: walks instruction sequences through the
// FSM and compares the packed control word and retired count against hand-derived
// values. Small MAX_WAIT and CNT_W keep timeout and wrap cases short.
module tb_multicycle_ctrl;
    logic clk;
    logic rstN;
    int   checkCount;
    int   failCount;

    multicycle_ctrl_if #(.CNT_W(4)) bus ();

    multicycle_ctrl #(.MAX_WAIT(4), .CNT_W(4)) dut (
        .clk_i (clk),
        .rst_i (rstN),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Packs a control word: memReq iord memWe irWrite pcWrite pcSrc regWrite regDst memToReg aluSrcA aluSrcB aluOp trap
    function automatic logic [18:0] mk(input logic memReq, input logic iord, input logic memWe,
                                       input logic irWrite, input logic pcWrite, input logic [1:0] pcSrc,
                                       input logic regWrite, input logic [1:0] regDst,
                                       input logic [1:0] memToReg, input logic aluSrcA,
                                       input logic [1:0] aluSrcB, input logic [2:0] aluOp,
                                       input logic trap);
        return {memReq, iord, memWe, irWrite, pcWrite, pcSrc, regWrite, regDst,
                memToReg, aluSrcA, aluSrcB, aluOp, trap};
    endfunction

    function automatic logic [18:0] observed();
        return {bus.mem_req_o, bus.iord_o, bus.mem_we_o, bus.ir_write_o, bus.pc_write_o,
                bus.pc_src_o, bus.reg_write_o, bus.reg_dst_o, bus.mem_to_reg_o,
                bus.alu_src_a_o, bus.alu_src_b_o, bus.alu_op_o, bus.trap_o};
    endfunction

    logic [18:0] ctlIdle, fetchRdy, fetchWait, decBase, decJ, decJal, decJr;
    logic [18:0] exR, exOri, exSlti, exMem, exBrTaken, exBrNot, memLw, memSw;
    logic [18:0] wbR, wbLw, wbI, trapWord;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            failCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] funct,
                                 input logic zero, input logic ready);
        bus.instr_op_i  = op;
        bus.funct_i     = funct;
        bus.zero_i      = zero;
        bus.mem_ready_i = ready;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkCtl(input string tag, input logic [18:0] exp);
        checkOutput(tag, {13'd0, observed()}, {13'd0, exp});
    endtask

    task automatic checkCnt(input string tag, input logic [3:0] exp);
        checkOutput(tag, {28'd0, bus.instr_cnt_o}, {28'd0, exp});
    endtask

    task automatic fetchOk(input logic [5:0] op, input logic [5:0] funct, input string tag);
        applyStimulus(op, funct, 1'b0, 1'b1);
        checkCtl(tag, fetchRdy);
        tick();
    endtask

    task automatic doReset();
        rstN = 1'b0;
        #1;
        checkCtl("reset_ctl", ctlIdle);
        checkCnt("reset_cnt", 4'd0);
        tick();
        rstN = 1'b1;
        #1;
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        ctlIdle   = '0;
        fetchRdy  = mk(1,0,0,1,1,2'd0,0,2'd0,2'd0,0,2'd1,3'd0,0);
        fetchWait = mk(1,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd1,3'd0,0);
        decBase   = mk(0,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd3,3'd0,0);
        decJ      = mk(0,0,0,0,1,2'd2,0,2'd0,2'd0,0,2'd3,3'd0,0);
        decJal    = mk(0,0,0,0,1,2'd2,1,2'd2,2'd3,0,2'd3,3'd0,0);
        decJr     = mk(0,0,0,0,1,2'd3,0,2'd0,2'd0,0,2'd3,3'd0,0);
        exR       = mk(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,2'd0,3'd2,0);
        exOri     = mk(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,2'd2,3'd4,0);
        exSlti    = mk(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,2'd2,3'd3,0);
        exMem     = mk(0,0,0,0,0,2'd0,0,2'd0,2'd0,1,2'd2,3'd0,0);
        exBrTaken = mk(0,0,0,0,1,2'd1,0,2'd0,2'd0,1,2'd0,3'd1,0);
        exBrNot   = mk(0,0,0,0,0,2'd1,0,2'd0,2'd0,1,2'd0,3'd1,0);
        memLw     = mk(1,1,0,0,0,2'd0,0,2'd0,2'd0,0,2'd0,3'd0,0);
        memSw     = mk(1,1,1,0,0,2'd0,0,2'd0,2'd0,0,2'd0,3'd0,0);
        wbR       = mk(0,0,0,0,0,2'd0,1,2'd1,2'd0,0,2'd0,3'd0,0);
        wbLw      = mk(0,0,0,0,0,2'd0,1,2'd0,2'd1,0,2'd0,3'd0,0);
        wbI       = mk(0,0,0,0,0,2'd0,1,2'd0,2'd0,0,2'd0,3'd0,0);
        trapWord  = mk(0,0,0,0,0,2'd0,0,2'd0,2'd0,0,2'd0,3'd0,1);

        rstN = 1'b0;
        applyStimulus(6'd0, 6'd32, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        checkCtl("reset_ctl", ctlIdle);
        checkCnt("reset_cnt", 4'd0);
        rstN = 1'b1;
        #1;
        checkCtl("idle_ctl", ctlIdle);
        tick();

        // add $3,$1,$2
        fetchOk(6'd0, 6'd32, "add_fetch");
        checkCtl("add_decode", decBase);
        tick();
        checkCtl("add_exec", exR);
        tick();
        checkCtl("add_wb", wbR);
        checkCnt("add_cnt_wb", 4'd0);
        tick();
        checkCnt("add_cnt", 4'd1);

        // lw with three memory wait cycles
        fetchOk(6'd35, 6'd0, "lw_fetch");
        checkCtl("lw_decode", decBase);
        tick();
        checkCtl("lw_exec", exMem);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(6'd35, 6'd0, 1'b0, (i == 3));
            checkCtl("lw_mem", memLw);
            tick();
        end
        checkCtl("lw_wb", wbLw);
        tick();
        checkCnt("lw_cnt", 4'd2);

        // beq taken, bne not taken, bne taken
        fetchOk(6'd4, 6'd0, "beq_fetch");
        checkCtl("beq_decode", decBase);
        tick();
        applyStimulus(6'd4, 6'd0, 1'b1, 1'b1);
        checkCtl("beq_exec_z1", exBrTaken);
        tick();
        checkCnt("beq_cnt", 4'd3);
        fetchOk(6'd5, 6'd0, "bne_fetch");
        tick();
        applyStimulus(6'd5, 6'd0, 1'b1, 1'b1);
        checkCtl("bne_exec_z1", exBrNot);
        tick();
        checkCnt("bne_cnt", 4'd4);
        fetchOk(6'd5, 6'd0, "bne2_fetch");
        tick();
        applyStimulus(6'd5, 6'd0, 1'b0, 1'b1);
        checkCtl("bne_exec_z0", exBrTaken);
        tick();
        checkCnt("bne2_cnt", 4'd5);

        // jal then jr $31
        fetchOk(6'd3, 6'd0, "jal_fetch");
        checkCtl("jal_decode", decJal);
        tick();
        checkCnt("jal_cnt", 4'd6);
        fetchOk(6'd0, 6'd8, "jr_fetch");
        checkCtl("jr_decode", decJr);
        tick();
        checkCnt("jr_cnt", 4'd7);

        // ori and slti
        fetchOk(6'd13, 6'd0, "ori_fetch");
        tick();
        checkCtl("ori_exec", exOri);
        tick();
        checkCtl("ori_wb", wbI);
        tick();
        fetchOk(6'd10, 6'd0, "slti_fetch");
        tick();
        checkCtl("slti_exec", exSlti);
        tick();
        checkCtl("slti_wb", wbI);
        tick();
        checkCnt("imm_cnt", 4'd9);

        // sw completing after one wait cycle goes straight back to FETCH
        fetchOk(6'd43, 6'd0, "sw_fetch");
        tick();
        checkCtl("sw_exec", exMem);
        tick();
        applyStimulus(6'd43, 6'd0, 1'b0, 1'b0);
        checkCtl("sw_mem_wait", memSw);
        tick();
        applyStimulus(6'd43, 6'd0, 1'b0, 1'b1);
        checkCtl("sw_mem_done", memSw);
        tick();
        checkCnt("sw_cnt", 4'd10);
        applyStimulus(6'd43, 6'd0, 1'b0, 1'b0);
        checkCtl("sw_next_fetch", fetchWait);

        // sw abandoned by reset during MEM
        fetchOk(6'd43, 6'd0, "sw2_fetch");
        tick();
        tick();
        applyStimulus(6'd43, 6'd0, 1'b0, 1'b0);
        checkCtl("sw2_mem", memSw);
        doReset();
        checkCtl("post_reset_idle", ctlIdle);
        tick();

        // fetch timeout traps after MAX_WAIT cycles and holds
        for (int i = 0; i < 4; i++) begin
            applyStimulus(6'd0, 6'd32, 1'b0, 1'b0);
            checkCtl("timeout_fetch", fetchWait);
            tick();
        end
        checkCtl("timeout_trap", trapWord);
        applyStimulus(6'd0, 6'd32, 1'b0, 1'b1);
        tick();
        checkCtl("trap_hold1", trapWord);
        tick();
        checkCtl("trap_hold2", trapWord);

        // ready on the last allowed cycle completes normally; opcode 63 traps
        doReset();
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(6'd63, 6'd0, 1'b0, (i == 3));
            checkCtl("late_fetch", (i == 3) ? fetchRdy : fetchWait);
            tick();
        end
        checkCtl("ill_decode", decBase);
        tick();
        checkCtl("ill_trap", trapWord);
        checkCnt("ill_cnt", 4'd0);

        // retired counter wraps at 2^CNT_W
        doReset();
        tick();
        for (int k = 0; k < 16; k++) begin
            fetchOk(6'd2, 6'd0, "j_fetch");
            applyStimulus(6'd2, 6'd0, 1'b0, 1'b1);
            if (k == 0) checkCtl("j_decode", decJ);
            tick();
            if (k == 14) checkCnt("cnt_max", 4'd15);
        end
        checkCnt("cnt_wrap", 4'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end
endmodule
